// File: rtl/uart_tx.sv
`timescale 1ns/1ps
// UART transmitter: pops bytes from a show-ahead FIFO and sends start, 8 data bits
// MSB first, optional parity (build with UART_TX_PARITY_EN) and one stop bit.
module uart_tx (
  input  logic        sclk,
  input  logic        rstn,
  input  logic        tx_en_i,
  input  logic [15:0] baud_div_r,
  input  logic [1:0]  parity_r,
  input  logic        fifo_empty_i,
  input  logic [7:0]  fifo_data_i,
  output logic        fifo_rd_o,
  output logic        tx_o,
  output logic        busy_o,
  output logic        tx_done_o
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]  state;
  logic [15:0] baud_cnt;
  logic [15:0] div_q;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_q;
  logic        tx_q;
  logic        busy_q;
  logic        start_frame;
  logic        bit_end;

`ifdef UART_TX_PARITY_EN
  logic        par_en_q;
  logic        par_bit_q;
`else
  logic        parity_unused;
  assign parity_unused = ^parity_r;
`endif

  assign start_frame = (state == IDLE) && tx_en_i && !fifo_empty_i;
  // The pop is decoded combinationally so the start bit can appear on the very next cycle.
  assign fifo_rd_o   = rstn && start_frame;
  assign bit_end     = (baud_cnt == div_q);
  assign tx_done_o   = (state == STOP) && bit_end;
  assign tx_o        = tx_q;
  assign busy_o      = busy_q;

  // NOTE: every register below is state, so only non-blocking assignments are used; blocking
  // assignments here would make later statements see same-edge values and break ordering.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      div_q     <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      if (state != IDLE) begin
        baud_cnt <= bit_end ? 16'd0 : baud_cnt + 16'd1;
      end

      case (state)
        IDLE: begin
          if (start_frame) begin
            shift_q   <= fifo_data_i;
            div_q     <= baud_div_r;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            state     <= START;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= parity_r[1];
            par_bit_q <= (^fifo_data_i) ^ ~parity_r[0];
`endif
          end
        end

        START: begin
          if (bit_end) begin
            tx_q  <= shift_q[7];
            state <= DATA;
          end
        end

        DATA: begin
          if (bit_end) begin
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              if (par_en_q) begin
                tx_q  <= par_bit_q;
                state <= PARITY;
              end else begin
                tx_q  <= 1'b1;
                state <= STOP;
              end
`else
              tx_q  <= 1'b1;
              state <= STOP;
`endif
            end else begin
              shift_q <= {shift_q[6:0], 1'b0};
              tx_q    <= shift_q[6];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            tx_q  <= 1'b1;
            state <= STOP;
          end
        end
`endif

        STOP: begin
          if (bit_end) begin
            busy_q  <= 1'b0;
            bit_cnt <= '0;
            state   <= IDLE;
          end
        end

        default: begin
          // Unreachable encodings recover to a quiet idle line.
          state    <= IDLE;
          tx_q     <= 1'b1;
          busy_q   <= 1'b0;
          baud_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
// Self-checking bench for uart_tx: table of frames plus hand-written sequences for
// back-to-back frames, mid-frame divisor change and mid-frame reset.
module tb_uart_tx;

  logic        sclk = 1'b0;
  logic        rstn = 1'b0;
  logic        tx_en = 1'b0;
  logic [15:0] baud_div = '0;
  logic [1:0]  parity = '0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_data = '0;
  logic        fifo_rd;
  logic        tx;
  logic        busy;
  logic        tx_done;

  uart_tx dut (
    .sclk        (sclk),
    .rstn        (rstn),
    .tx_en_i     (tx_en),
    .baud_div_r  (baud_div),
    .parity_r    (parity),
    .fifo_empty_i(fifo_empty),
    .fifo_data_i (fifo_data),
    .fifo_rd_o   (fifo_rd),
    .tx_o        (tx),
    .busy_o      (busy),
    .tx_done_o   (tx_done)
  );

  always #5 sclk = ~sclk;

  // Expected line: bits[nbits-1] is sent first, each bit lasts div+1 cycles.
  typedef struct {
    logic [10:0] bits;
    int          nbits;
    int          div;
  } frame_t;

  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    logic [1:0]  par;
    logic [10:0] bits;
    int          nbits;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rd_count = 0;
  int done_count = 0;
  int frames_seen = 0;
  int idle_err = 0;
  int underflow_err = 0;
  int last_end_cyc = -100;
  int last_gap = -1;
  bit mon_off = 1'b0;

  logic [7:0] fifo_q[$];
  frame_t     exp_q[$];
  vec_t       vecs[8];
  int         nvec;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fifo_sync();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic send(input logic [7:0] d, input logic [10:0] bits, input int nbits, input int div);
    frame_t f;
    f.bits  = bits;
    f.nbits = nbits;
    f.div   = div;
    fifo_q.push_back(d);
    exp_q.push_back(f);
    fifo_sync();
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (frames_seen < target && n < budget) begin
      @(negedge sclk);
      n++;
    end
    check("frames_seen", frames_seen, target);
  endtask

  task automatic wait_tx_low(input int budget);
    int n;
    n = 0;
    while (tx !== 1'b0 && n < budget) begin
      @(negedge sclk);
      n++;
    end
    check("start_bit_seen", tx, 1'b0);
  endtask

  always @(posedge sclk) cyc <= cyc + 1;

  always @(negedge sclk) if (tx_done === 1'b1) done_count <= done_count + 1;

  // Show-ahead FIFO model: the head leaves right after the edge that saw the pop strobe.
  always begin
    @(negedge sclk);
    #1;
    if (fifo_rd === 1'b1) begin
      @(posedge sclk);
      #1;
      rd_count++;
      if (fifo_q.size() == 0) underflow_err++;
      else void'(fifo_q.pop_front());
      fifo_sync();
    end
  end

  task automatic run_frame(input frame_t f);
    int len;
    int idx;
    int bit_err;
    int busy_err;
    int done_err;
    len      = f.nbits * (f.div + 1);
    bit_err  = 0;
    busy_err = 0;
    done_err = 0;
    last_gap = cyc - last_end_cyc - 1;
    for (int c = 0; c < len; c++) begin
      if (c > 0) @(negedge sclk);
      idx = f.nbits - 1 - c / (f.div + 1);
      if (tx !== f.bits[idx]) bit_err++;
      if (busy !== 1'b1) busy_err++;
      if (tx_done !== ((c == len - 1) ? 1'b1 : 1'b0)) done_err++;
    end
    last_end_cyc = cyc;
    frames_seen++;
    check("frame_bits", bit_err, 0);
    check("frame_busy", busy_err, 0);
    check("frame_done", done_err, 0);
  endtask

  // Line monitor: pops the scoreboard on each start bit, otherwise expects a quiet idle line.
  always begin
    @(negedge sclk);
    if (rstn === 1'b1 && !mon_off) begin
      if (tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
          for (int k = 0; k < 4000 && tx !== 1'b1; k++) @(negedge sclk);
        end else begin
          run_frame(exp_q.pop_front());
        end
      end else if (busy !== 1'b0 || tx_done !== 1'b0) begin
        idle_err++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int target;
    int rd_before;
    int rd_snap;
    int done_snap;
    int tx_low;
    int busy_hi;

    // Leading pad bit keeps 10-bit frames in the 11-bit field.
    nvec = 6;
    vecs[0] = '{8'hA5, 16'd3, 2'b00, 11'b0_0_10100101_1, 10};
    vecs[1] = '{8'h3C, 16'd1, 2'b00, 11'b0_0_00111100_1, 10};
    vecs[2] = '{8'h00, 16'd0, 2'b00, 11'b0_0_00000000_1, 10};
    vecs[3] = '{8'hC3, 16'd4, 2'b01, 11'b0_0_11000011_1, 10};
`ifdef UART_TX_PARITY_EN
    vecs[4] = '{8'h81, 16'd2, 2'b11, 11'b0_10000001_0_1, 11};
    vecs[5] = '{8'h5A, 16'd5, 2'b10, 11'b0_01011010_1_1, 11};
    vecs[6] = '{8'hA5, 16'd3, 2'b11, 11'b0_10100101_0_1, 11};
    vecs[7] = '{8'hA5, 16'd3, 2'b10, 11'b0_10100101_1_1, 11};
    nvec = 8;
`else
    vecs[4] = '{8'h81, 16'd2, 2'b11, 11'b0_0_10000001_1, 10};
    vecs[5] = '{8'h5A, 16'd5, 2'b10, 11'b0_0_01011010_1, 10};
`endif

    // Reset state, including no pop while held in reset with a non-empty FIFO.
    fifo_sync();
    repeat (3) @(negedge sclk);
    check("reset_tx", tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_done", tx_done, 1'b0);
    fifo_q.push_back(8'h11);
    fifo_sync();
    tx_en = 1'b1;
    #1;
    check("reset_rd", fifo_rd, 1'b0);
    fifo_q.delete();
    fifo_sync();
    tx_en = 1'b0;
    @(negedge sclk);
    rstn = 1'b1;
    repeat (3) @(negedge sclk);
    check("post_reset_tx", tx, 1'b1);
    check("post_reset_rd_count", rd_count, 0);

    // Table-driven single frames.
    target = 0;
    for (int i = 0; i < nvec; i++) begin
      baud_div = vecs[i].div;
      parity   = vecs[i].par;
      tx_en    = 1'b1;
      send(vecs[i].data, vecs[i].bits, vecs[i].nbits, int'(vecs[i].div));
      target++;
      wait_frames(target, 200);
      check("pop_count", rd_count, target);
    end
    tx_en  = 1'b0;
    parity = 2'b00;
    @(negedge sclk);

    // Back-to-back 0x00 then 0xFF at one-cycle bits.
    baud_div  = 16'd0;
    rd_before = rd_count;
    send(8'h00, 11'b0_0_00000000_1, 10, 0);
    send(8'hFF, 11'b0_0_11111111_1, 10, 0);
    tx_en = 1'b1;
    target += 2;
    wait_frames(target, 100);
    check("b2b_gap", last_gap, 1);
    check("b2b_pops", rd_count - rd_before, 2);
    repeat (20) @(negedge sclk);
    check("no_pop_when_empty", rd_count - rd_before, 2);
    check("fifo_underflow", underflow_err, 0);

    // Divisor change and tx_en drop during DATA do not disturb the frame in flight.
    tx_en    = 1'b0;
    baud_div = 16'd3;
    @(negedge sclk);
    send(8'h3C, 11'b0_0_00111100_1, 10, 3);
    send(8'h3C, 11'b0_0_00111100_1, 10, 7);
    tx_en = 1'b1;
    wait_tx_low(10);
    repeat (10) @(negedge sclk);
    baud_div = 16'd7;
    tx_en    = 1'b0;
    repeat (8) @(negedge sclk);
    tx_en = 1'b1;
    target += 2;
    wait_frames(target, 300);
    tx_en = 1'b0;
    @(negedge sclk);

    // Reset during DATA: immediate idle, no done pulse, and no pop while tx_en is low.
    mon_off  = 1'b1;
    baud_div = 16'd3;
    tx_en    = 1'b1;
    fifo_q.push_back(8'h96);
    fifo_sync();
    wait_tx_low(10);
    repeat (12) @(negedge sclk);
    check("mid_frame_busy", busy, 1'b1);
    done_snap = done_count;
    rstn = 1'b0;
    #1;
    check("abort_tx", tx, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_rd", fifo_rd, 1'b0);
    tx_en = 1'b0;
    fifo_q.push_back(8'h69);
    fifo_sync();
    rd_snap = rd_count;
    repeat (3) @(negedge sclk);
    rstn   = 1'b1;
    tx_low = 0;
    busy_hi = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge sclk);
      if (tx !== 1'b1) tx_low++;
      if (busy !== 1'b0) busy_hi++;
    end
    check("abort_no_done", done_count - done_snap, 0);
    check("post_abort_tx_low", tx_low, 0);
    check("post_abort_busy", busy_hi, 0);
    check("post_abort_no_pop", rd_count - rd_snap, 0);
    check("post_abort_fifo", fifo_q.size(), 1);
    fifo_q.delete();
    fifo_sync();
    @(negedge sclk);
    mon_off = 1'b0;
    repeat (4) @(negedge sclk);

    check("scoreboard_empty", exp_q.size(), 0);
    check("idle_errors", idle_err, 0);
    check("underflow_final", underflow_err, 0);
    check("frames_total", frames_seen, target);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL provide ports: sclk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL provide: rstn  input  1  asynchronous active-low reset.
REQ-003 SHALL provide: tx_en_i  input  1  high permits new frames to start.
REQ-004 SHALL provide: baud_div_r  input  16  bit period = baud_div_r+1 sclk cycles.
REQ-005 SHALL provide: parity_r  input  2  [1] parity ON/OFF; [0] 1=even, 0=odd.
REQ-006 SHALL provide: fifo_empty_i  input  1  source FIFO empty.
REQ-007 SHALL provide: fifo_data_i  input  8  show-ahead FIFO head word, valid while fifo_empty_i low.
REQ-008 SHALL provide: fifo_rd_o  output  1  one-cycle pop strobe to source FIFO.
REQ-009 SHALL provide: tx_o  output  1  serial line, idle high.
REQ-010 SHALL provide: busy_o  output  1  high while a frame is on the line.
REQ-011 SHALL provide: tx_done_o  output  1  one-cycle pulse at end of stop bit.

Function
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-013 IDLE: when tx_en_i=1 and fifo_empty_i=0, SHALL assert fifo_rd_o for exactly one cycle, capture fifo_data_i, baud_div_r and parity_r in that same cycle, and enter START.
REQ-014 SHALL hold fifo_rd_o low in every state other than IDLE; there SHALL be no pop when fifo_empty_i=1.
REQ-015 Latency: tx_o SHALL go low on the cycle after fifo_rd_o; busy_o SHALL rise on that same cycle.
REQ-016 Each bit SHALL last exactly latched_div+1 cycles, timed by a 16-bit counter that clears at every bit boundary; baud_div_r=0 gives 1-cycle bits.
REQ-017 START SHALL drive tx_o=0 for one bit, then enter DATA.
REQ-018 DATA SHALL send 8 bits MSB first (bit 7 first) from a shift register, using a 3-bit counter; after bit 0, it SHALL enter PARITY when parity is enabled, else STOP.
REQ-019 PARITY bit SHALL be XOR of the 8 data bits when parity_r[0]=1 (even), and its inverse when parity_r[0]=0 (odd).
REQ-020 STOP SHALL drive tx_o=1 for one bit; on its last cycle, tx_done_o SHALL pulse and the state SHALL return to IDLE.
REQ-021 Back-to-back frames SHALL be separated by exactly one sclk cycle of IDLE (tx_o=1, busy_o=0), in which the next pop may occur.
REQ-022 Changes to baud_div_r or parity_r mid-frame SHALL NOT affect the current frame.
REQ-023 tx_en_i deasserted mid-frame SHALL NOT abort the frame; it SHALL only block the next start.
REQ-024 An unused state encoding SHALL return to IDLE with tx_o=1 on the next cycle.

Reset
REQ-025 On rstn=0, the block SHALL immediately enter IDLE and set tx_o=1, busy_o=0, fifo_rd_o=0, tx_done_o=0, and all counters and shift/latch registers to 0.
REQ-026 Reset mid-frame SHALL abort the frame with no tx_done_o pulse; after release, the block SHALL be idle-high until the next pop.

Configuration
REQ-027 With macro UART_TX_PARITY_EN defined, the PARITY state SHALL be built and used when the latched parity_r[1]=1.
REQ-028 Without UART_TX_PARITY_EN, the PARITY state SHALL not exist, parity_r SHALL be ignored, and every frame SHALL be start + 8 data + stop.

Verification
REQ-029 Scenario 1: baud_div_r=3, parity off, FIFO holds 0xA5 -> one fifo_rd_o pulse; tx_o = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; tx_done_o pulses once; busy_o high for 40 cycles.
REQ-030 Scenario 2: UART_TX_PARITY_EN defined, parity_r=2'b11 (even), data 0xA5 -> parity bit 0; with parity_r=2'b10 (odd) -> parity bit 1; frame is 11 bits (44 cycles at div 3).
REQ-031 Scenario 3: FIFO holds 0x00 then 0xFF, baud_div_r=0 -> two frames separated by exactly 1 idle cycle; two fifo_rd_o pulses; no pop once fifo_empty_i=1.
REQ-032 Scenario 4: baud_div_r changed from 3 to 7 during DATA of 0x3C -> current frame keeps 4-cycle bits; next frame uses 8-cycle bits.
REQ-033 Scenario 5: rstn pulsed low during DATA -> tx_o=1 and busy_o=0 immediately; no tx_done_o; with tx_en_i=0 and FIFO non-empty after release -> no pop and tx_o stays 1.
